// File: rtl/regslv_reg_block_1_if.sv
// Native register bus: single-outstanding request/acknowledge handshake.
// Used for the upstream port (64/32) and the ext_mem_1 port (1/128).
interface regslv_reg_block_1_if #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 32
);
   logic                  req_vld;
   logic                  req_rdy;
   logic                  ack_vld;
   logic                  ack_rdy;
   logic                  wr_en;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [DATA_WIDTH-1:0] rd_data;

   modport master (
      output req_vld, wr_en, rd_en, addr, wr_data, ack_rdy,
      input  req_rdy, ack_vld, rd_data
   );

   modport slave (
      input  req_vld, wr_en, rd_en, addr, wr_data, ack_rdy,
      output req_rdy, ack_vld, rd_data
   );
endinterface

// File: rtl/regslv_reg_block_1.sv
// Register slave for reg_block_1: 64-bit REG1.FIELD_0 plus a bridge to the 2x128-bit ext_mem_1,
// with per-target snapshots for atomic multi-word access. Option: `define REGSLV_GLB_SRST_EN.
module regslv_reg_block_1 #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 32
) (
   input  logic                        clk,
   input  logic                        rstn,
   regslv_reg_block_1_if.slave         s_up,
   regslv_reg_block_1_if.master        m_ext,
   input  logic                        i_global_sync_reset_in,
   output logic                        o_global_sync_reset_out,
   output logic                        o_cdc_pulse_out,
   input  logic [63:0]                 i_reg1_field_0_next_value,
   input  logic                        i_reg1_field_0_pulse,
   output logic [63:0]                 o_reg1_field_0_curr_value
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXT_REQ,
      S_EXT_WAIT,
      S_ACK
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   // Address decode (only addr[5:0] is significant)
   logic [ADDR_WIDTH-1:0] w_up_addr;
   logic [DATA_WIDTH-1:0] w_up_wdata;
   logic [5:0]            w_off;
   logic [31:0]           w_wdata;
   logic                  w_unused_addr;
   logic                  w_aligned;
   logic                  w_hit_reg1;
   logic                  w_hit_ext;
   logic                  w_ext_sel;
   logic [1:0]            w_word;
   logic [1:0]            w_ext_idx;
   logic                  w_accept;
   logic                  w_go_ext;
   logic                  w_reg1_commit;
   logic                  w_ext_rd_done;
   logic                  w_soft_clr;

   assign w_up_addr     = s_up.addr;
   assign w_up_wdata    = s_up.wr_data;
   assign w_off         = w_up_addr[5:0];
   assign w_wdata       = w_up_wdata[31:0];
   assign w_unused_addr = &{1'b0, w_up_addr[ADDR_WIDTH-1:6]};

   assign w_aligned     = (w_off[1:0] == 2'b00);
   assign w_hit_reg1    = w_aligned && (w_off[5:3] == 3'b000);
   assign w_hit_ext     = w_aligned && ((w_off[5:4] == 2'b01) || (w_off[5:4] == 2'b10));
   assign w_ext_sel     = w_off[5];
   assign w_word        = w_off[3:2];
   assign w_ext_idx     = w_word - 2'd1;

   assign w_accept      = (r_state == S_IDLE) && s_up.req_vld;
   assign w_go_ext      = w_accept && w_hit_ext && (w_word == 2'd0);
   assign w_reg1_commit = w_accept && s_up.wr_en && w_hit_reg1 && !w_off[2];

   // Registers and snapshot buffers
   logic [63:0]            r_reg1;
   logic [31:0]            r_wsnap_reg1;
   logic [31:0]            r_rsnap_reg1;
   logic [1:0][2:0][31:0]  r_wsnap_ext;
   logic [1:0][2:0][31:0]  r_rsnap_ext;

   // Transaction context
   logic [31:0]            r_rd_data;
   logic                   r_ext_wr;
   logic                   r_ext_sel;
   logic [127:0]           r_ext_wdata;

   assign w_ext_rd_done = (r_state == S_EXT_WAIT) && m_ext.ack_vld && !r_ext_wr;

`ifdef REGSLV_GLB_SRST_EN
   logic r_gsr_out;

   assign w_soft_clr = i_global_sync_reset_in;

   always_ff @(posedge clk) begin
      if (!rstn) r_gsr_out <= 1'b0;
      else       r_gsr_out <= i_global_sync_reset_in;
   end

   assign o_global_sync_reset_out = r_gsr_out;
`else
   assign w_soft_clr              = 1'b0;
   assign o_global_sync_reset_out = i_global_sync_reset_in;
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // NOTE: default assigned first so no path through this block leaves a value unassigned (no latch).
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_nxt = w_go_ext ? S_EXT_REQ : S_ACK;
         end
         S_EXT_REQ: begin
            if (m_ext.req_rdy) w_state_nxt = S_EXT_WAIT;
         end
         S_EXT_WAIT: begin
            if (m_ext.ack_vld) w_state_nxt = S_ACK;
         end
         S_ACK: begin
            if (s_up.ack_rdy) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: snapshot arrays are reset explicitly because a stale upper word would leak into the next commit.
   always_ff @(posedge clk) begin
      if (!rstn || w_soft_clr) begin
         r_reg1       <= '0;
         r_wsnap_reg1 <= '0;
         r_rsnap_reg1 <= '0;
         r_wsnap_ext  <= '0;
         r_rsnap_ext  <= '0;
      end else begin
         // Software commit has priority over the hardware load strobe
         if (w_reg1_commit)              r_reg1 <= {r_wsnap_reg1, w_wdata};
         else if (i_reg1_field_0_pulse)  r_reg1 <= i_reg1_field_0_next_value;

         if (w_accept && w_hit_reg1) begin
            if (s_up.wr_en) begin
               if (w_off[2]) r_wsnap_reg1 <= w_wdata;
            end else if (!w_off[2]) begin
               r_rsnap_reg1 <= r_reg1[63:32];
            end
         end

         if (w_accept && w_hit_ext && (w_word != 2'd0) && s_up.wr_en)
            r_wsnap_ext[w_ext_sel][w_ext_idx] <= w_wdata;

         if (w_ext_rd_done)
            r_rsnap_ext[r_ext_sel] <= m_ext.rd_data[127:32];
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_rd_data   <= '0;
         r_ext_wr    <= 1'b0;
         r_ext_sel   <= 1'b0;
         r_ext_wdata <= '0;
      end else begin
         if (w_accept) begin
            r_rd_data <= '0;
            if (!s_up.wr_en) begin
               if (w_hit_reg1)
                  r_rd_data <= w_off[2] ? r_rsnap_reg1 : r_reg1[31:0];
               else if (w_hit_ext && (w_word != 2'd0))
                  r_rd_data <= r_rsnap_ext[w_ext_sel][w_ext_idx];
            end
            if (w_go_ext) begin
               r_ext_wr  <= s_up.wr_en;
               r_ext_sel <= w_ext_sel;
               if (s_up.wr_en) r_ext_wdata <= {r_wsnap_ext[w_ext_sel], w_wdata};
            end
         end
         if (w_ext_rd_done) r_rd_data <= m_ext.rd_data[31:0];
      end
   end

   assign s_up.req_rdy  = (r_state == S_IDLE);
   assign s_up.ack_vld  = (r_state == S_ACK);
   assign s_up.rd_data  = r_rd_data;

   assign m_ext.req_vld = (r_state == S_EXT_REQ);
   assign m_ext.wr_en   = m_ext.req_vld && r_ext_wr;
   assign m_ext.rd_en   = m_ext.req_vld && !r_ext_wr;
   assign m_ext.addr    = r_ext_sel;
   assign m_ext.wr_data = r_ext_wdata;
   assign m_ext.ack_rdy = 1'b1;

   assign o_cdc_pulse_out           = 1'b0;
   assign o_reg1_field_0_curr_value = r_reg1;

endmodule

// File: tb/tb_regslv_reg_block_1.sv
// Self-checking bench for regslv_reg_block_1: upstream driver with read scoreboard,
// behavioural ext_mem_1 slave with programmable ready/ack delays.
module tb_regslv_reg_block_1;

   logic clk;
   logic rstn;
   logic gsr_in;
   logic gsr_out;
   logic cdc_pulse;
   logic [63:0] next_value;
   logic pulse;
   logic [63:0] curr_value;

   regslv_reg_block_1_if #(.ADDR_WIDTH(64), .DATA_WIDTH(32))  up ();
   regslv_reg_block_1_if #(.ADDR_WIDTH(1),  .DATA_WIDTH(128)) ext ();

   regslv_reg_block_1 #(.ADDR_WIDTH(64), .DATA_WIDTH(32)) dut (
      .clk                       (clk),
      .rstn                      (rstn),
      .s_up                      (up),
      .m_ext                     (ext),
      .i_global_sync_reset_in    (gsr_in),
      .o_global_sync_reset_out   (gsr_out),
      .o_cdc_pulse_out           (cdc_pulse),
      .i_reg1_field_0_next_value (next_value),
      .i_reg1_field_0_pulse      (pulse),
      .o_reg1_field_0_curr_value (curr_value)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0]  exp_q[$];
   logic [127:0] mem [2];
   int           ext_rdy_hold  = 0;
   int           ext_ack_delay = 0;

   localparam logic [127:0] ALL_ONES = {128{1'b1}};
   localparam logic [127:0] ALL_AA   = {16{8'haa}};

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
      else             n_pass++;
   endtask

   // Behavioural ext_mem_1 slave
   initial begin
      logic         m_wr;
      logic         m_a;
      logic [127:0] m_wd;
      ext.req_rdy = 1'b0;
      ext.ack_vld = 1'b0;
      ext.rd_data = '0;
      forever begin
         @(negedge clk);
         if (ext.req_vld === 1'b1) begin
            for (int i = 0; i < ext_rdy_hold; i++) begin
               check("ext_hold_req_vld", ext.req_vld, 1);
               check("ext_hold_wr_en",   ext.wr_en,   1);
               check("ext_hold_up_ack",  up.ack_vld,  0);
               @(negedge clk);
            end
            ext.req_rdy = 1'b1;
            m_wr = ext.wr_en;
            m_a  = ext.addr;
            m_wd = ext.wr_data;
            @(negedge clk);
            ext.req_rdy = 1'b0;
            if (m_wr) mem[m_a] = m_wd;
            else      ext.rd_data = mem[m_a];
            repeat (ext_ack_delay) @(negedge clk);
            ext.ack_vld = 1'b1;
            @(negedge clk);
            ext.ack_vld = 1'b0;
         end
      end
   end

   // One upstream transaction; for reads, data is the expected read value.
   task automatic xact(input string tag, input logic wr, input logic [63:0] a,
                       input logic [31:0] data, input int ack_hold, output int lat);
      int n;
      logic [31:0] exp;
      @(negedge clk);
      up.req_vld = 1'b1;
      up.wr_en   = wr;
      up.rd_en   = !wr;
      up.addr    = a;
      up.wr_data = wr ? data : 32'h0;
      if (!wr) exp_q.push_back(data);
      n = 0;
      while (!up.req_rdy && n < 50) begin @(negedge clk); n++; end
      if (!up.req_rdy) begin
         check({tag, "_req_rdy_timeout"}, 0, 1);
         up.req_vld = 1'b0;
         if (!wr) void'(exp_q.pop_front());
         lat = -1;
         return;
      end
      @(posedge clk);
      #1;
      up.req_vld = 1'b0;
      up.wr_en   = 1'b0;
      up.rd_en   = 1'b0;
      if (ack_hold > 0) up.ack_rdy = 1'b0;
      lat = 0;
      @(negedge clk);
      while (!up.ack_vld && lat < 50) begin @(negedge clk); lat++; end
      if (!up.ack_vld) begin
         check({tag, "_ack_timeout"}, 0, 1);
         up.ack_rdy = 1'b1;
         if (!wr) void'(exp_q.pop_front());
         return;
      end
      if (!wr) exp = exp_q.pop_front();
      else     exp = 32'h0;
      for (int i = 0; i < ack_hold; i++) begin
         check({tag, "_hold_ack_vld"}, up.ack_vld, 1);
         check({tag, "_hold_req_rdy"}, up.req_rdy, 0);
         if (!wr) check({tag, "_hold_rd_data"}, up.rd_data, exp);
         @(negedge clk);
      end
      up.ack_rdy = 1'b1;
      if (!wr) check(tag, up.rd_data, exp);
      @(posedge clk);
      #1;
   endtask

   task automatic hw_pulse(input logic [63:0] v);
      @(negedge clk);
      next_value = v;
      pulse      = 1'b1;
      @(negedge clk);
      pulse      = 1'b0;
   endtask

   initial begin
      int lat;
      rstn       = 1'b0;
      gsr_in     = 1'b0;
      next_value = '0;
      pulse      = 1'b0;
      up.req_vld = 1'b0;
      up.wr_en   = 1'b0;
      up.rd_en   = 1'b0;
      up.addr    = '0;
      up.wr_data = '0;
      up.ack_rdy = 1'b1;
      mem[0]     = '0;
      mem[1]     = '0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_req_rdy",     up.req_rdy,   1);
      check("rst_ack_vld",     up.ack_vld,   0);
      check("rst_rd_data",     up.rd_data,   0);
      check("rst_ext_req_vld", ext.req_vld,  0);
      check("rst_ext_ack_rdy", ext.ack_rdy,  1);
      check("rst_curr_value",  curr_value,   0);
      check("rst_gsr_out",     gsr_out,      0);
      check("rst_cdc_pulse",   cdc_pulse,    0);
      rstn = 1'b1;

      // Unmapped / aliasing reads with REG1 still zero, internal latency
      xact("rd_0x40", 0, 64'h40, 32'h0, 0, lat);
      check("rd_0x40_lat", lat, 0);
      xact("rd_0x08", 0, 64'h08, 32'h0, 0, lat);
      check("rd_0x08_lat", lat, 0);
      xact("wr_0x30", 1, 64'h30, 32'hdeadbeef, 0, lat);
      xact("rd_0x3c", 0, 64'h3c, 32'h0, 0, lat);
      check("unmapped_wr_no_effect", curr_value, 0);

      // REG1 atomic write
      xact("wr_reg1_w1", 1, 64'h04, 32'h11111111, 0, lat);
      check("reg1_w1_staged", curr_value, 0);
      hw_pulse(64'haaaaaaaa_aaaaaaaa);
      check("reg1_hw_load", curr_value, 64'haaaaaaaa_aaaaaaaa);
      xact("wr_reg1_w0", 1, 64'h00, 32'h22222222, 0, lat);
      check("reg1_commit", curr_value, 64'h11111111_22222222);

      // REG1 snapshot read
      xact("rd_reg1_w0", 0, 64'h00, 32'h22222222, 0, lat);
      check("rd_reg1_w0_lat", lat, 0);
      hw_pulse(64'haaaaaaaa_aaaaaaaa);
      check("reg1_hw_reload", curr_value, 64'haaaaaaaa_aaaaaaaa);
      xact("rd_reg1_w1_snap", 0, 64'h04, 32'h11111111, 0, lat);

      // Ext write atomicity, entry 0 then entry 1
      xact("wr_e0_w3", 1, 64'h1c, 32'hffffffff, 0, lat);
      xact("wr_e0_w2", 1, 64'h18, 32'hffffffff, 0, lat);
      xact("wr_e0_w1", 1, 64'h14, 32'hffffffff, 0, lat);
      check("e0_staged", mem[0], 0);
      mem[0] = ALL_AA;
      xact("wr_e0_w0", 1, 64'h10, 32'hffffffff, 0, lat);
      check("e0_commit", mem[0], ALL_ONES);
      xact("wr_e1_w3", 1, 64'h2c, 32'hffffffff, 0, lat);
      xact("wr_e1_w2", 1, 64'h28, 32'hffffffff, 0, lat);
      xact("wr_e1_w1", 1, 64'h24, 32'hffffffff, 0, lat);
      check("e1_staged", mem[1], 0);
      mem[1] = ALL_AA;
      xact("wr_e1_w0", 1, 64'h20, 32'hffffffff, 0, lat);
      check("e1_commit", mem[1], ALL_ONES);

      // Ext snapshot reads
      xact("rd_e0_w0", 0, 64'h10, 32'hffffffff, 0, lat);
      mem[0] = ALL_AA;
      xact("rd_e0_w1", 0, 64'h14, 32'hffffffff, 0, lat);
      check("rd_e0_w1_lat", lat, 0);
      xact("rd_e0_w2", 0, 64'h18, 32'hffffffff, 0, lat);
      xact("rd_e0_w3", 0, 64'h1c, 32'hffffffff, 0, lat);
      mem[1] = 128'h44444444_33333333_22222222_11111111;
      xact("rd_e1_w0", 0, 64'h20, 32'h11111111, 0, lat);
      xact("rd_e1_w1", 0, 64'h24, 32'h22222222, 0, lat);
      xact("rd_e1_w3", 0, 64'h2c, 32'h44444444, 0, lat);

      // Handshake back-pressure: ext ready held low, then upstream ack held
      ext_rdy_hold = 3;
      xact("wr_e0_rdy_hold", 1, 64'h10, 32'h12345678, 0, lat);
      ext_rdy_hold = 0;
      check("e0_rdy_hold_data", mem[0], {96'hffffffff_ffffffff_ffffffff, 32'h12345678});
      xact("rd_e0_ack_hold", 0, 64'h10, 32'h12345678, 3, lat);
      xact("rd_reg1_ack_hold", 0, 64'h00, 32'haaaaaaaa, 3, lat);

      // Reset while waiting for the external acknowledge
      ext_ack_delay = 10;
      @(negedge clk);
      up.req_vld = 1'b1;
      up.rd_en   = 1'b1;
      up.wr_en   = 1'b0;
      up.addr    = 64'h10;
      @(posedge clk);
      #1;
      up.req_vld = 1'b0;
      up.rd_en   = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_busy_req_rdy", up.req_rdy, 0);
      rstn = 1'b0;
      @(negedge clk);
      check("abort_req_rdy",     up.req_rdy,  1);
      check("abort_ack_vld",     up.ack_vld,  0);
      check("abort_ext_req_vld", ext.req_vld, 0);
      check("abort_curr_value",  curr_value,  0);
      rstn = 1'b1;
      repeat (15) @(negedge clk);
      ext_ack_delay = 0;
      xact("rd_reg1_w1_cleared", 0, 64'h04, 32'h0, 0, lat);
      xact("rd_e0_w1_cleared",   0, 64'h14, 32'h0, 0, lat);
      xact("wr_reg1_w0_after",   1, 64'h00, 32'h00000055, 0, lat);
      check("wsnap_cleared", curr_value, 64'h00000000_00000055);

      // Global sync reset forwarding
`ifdef REGSLV_GLB_SRST_EN
      @(negedge clk);
      gsr_in = 1'b1;
      #1;
      check("gsr_out_lag", gsr_out, 0);
      @(negedge clk);
      check("gsr_out_reg", gsr_out, 1);
      check("gsr_clears_reg1", curr_value, 0);
      gsr_in = 1'b0;
      @(negedge clk);
      check("gsr_out_release", gsr_out, 0);
`else
      @(negedge clk);
      gsr_in = 1'b1;
      #1;
      check("gsr_out_comb", gsr_out, 1);
      @(negedge clk);
      check("gsr_no_effect", curr_value, 64'h00000000_00000055);
      gsr_in = 1'b0;
      #1;
      check("gsr_out_release", gsr_out, 0);
`endif

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

endmodule
